weight_bank_ctrl: RTL and testbench

- Sequences loading of convolution weight kernels into the double-banked (ping-pong) weight register matrix.
- Accepts packed weight beats from read_op through a valid/ready handshake. Drives the shift-enable and write-bank select for the loading bank, and the read-bank select for the compute array.
- Tracks bank full/empty state so a new kernel group loads into one bank while the PE array consumes the other.
- Sits between read_op, weight_reg_matrix and the convolution engine control.

---
 rtl/cnn_acc_pkg.sv | 23 ++
 rtl/weight_bank_ctrl_bank_status.sv | 51 +++++
 rtl/weight_bank_ctrl.sv | 125 ++++++++++++
 tb/tb_weight_bank_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_acc_pkg.sv
// Shared types and geometry helpers for the CNN accelerator weight path.
// Beat/matrix sizing is derived from element width, beat width and kernel geometry.
package cnn_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    function automatic int package_len(input int fw, input int dw);
        return dw / fw;
    endfunction

    function automatic int matrix_len(input int ms, input int ks);
        return ms * ks * ks;
    endfunction

    function automatic int package_num(input int fw, input int dw, input int ms, input int ks);
        return matrix_len(ms, ks) / package_len(fw, dw);
    endfunction

endpackage

// File: rtl/weight_bank_ctrl_bank_status.sv
// Ping-pong bank bookkeeping: full flags plus write/read bank pointers; updates land next edge.
// Set needs an empty write bank and clear needs a full read bank, so both may apply together.
module bank_status (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       set_i,
    input  logic       clr_i,
    output logic [1:0] full_o,
    output logic       wr_bank_o,
    output logic       rd_bank_o
);

    logic [1:0] full_q, full_d;
    logic       wr_q, wr_d;
    logic       rd_q, rd_d;
    logic       clr;

    // A done request against an empty read bank is dropped.
    assign clr = clr_i && full_q[rd_q];

    always_comb begin
        full_d = full_q;
        wr_d   = wr_q;
        rd_d   = rd_q;
        if (set_i) begin
            full_d[wr_q] = 1'b1;
            wr_d         = ~wr_q;
        end
        if (clr) begin
            full_d[rd_q] = 1'b0;
            rd_d         = ~rd_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            full_q <= 2'b00;
            wr_q   <= 1'b0;
            rd_q   <= 1'b0;
        end else begin
            full_q <= full_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
        end
    end

    assign full_o    = full_q;
    assign wr_bank_o = wr_q;
    assign rd_bank_o = rd_q;

endmodule

// File: rtl/weight_bank_ctrl.sv
// Sequences weight beats into the ping-pong weight matrix; shift enable is combinational on handshake.
// rd_ready_o drops while the write bank is still full; done pulses are registered (one cycle late).
module weight_bank_ctrl
    import cnn_acc_pkg::*;
#(
    parameter int FW = 16,
    parameter int DW = 512,
    parameter int MS = 32,
    parameter int KS = 3,
    parameter int GW = 16
) (
    input  logic          clk_i,
    input  logic          rstn_i,
    input  logic          start_i,
    input  logic [GW-1:0] mat_num_i,
    input  logic          rd_valid_i,
    output logic          rd_ready_o,
    output logic          wm_en_o,
    output logic          wm_sel_w_o,
    output logic          wm_sel_r_o,
    output logic          wt_valid_o,
    input  logic          wt_done_i,
    output logic          busy_o,
    output logic          load_done_o,
    output logic          layer_done_o
);

    localparam int            PACKAGE_NUM = package_num(FW, DW, MS, KS);
    localparam int            PW          = (PACKAGE_NUM > 1) ? $clog2(PACKAGE_NUM) : 1;
    localparam logic [PW-1:0] PKG_LAST    = PW'(PACKAGE_NUM - 1);

    state_t        state_q, state_d;
    logic [PW-1:0] pkg_cnt_q, pkg_cnt_d;
    logic [GW-1:0] mat_cnt_q, mat_cnt_d;
    logic [GW-1:0] mat_num_q, mat_num_d;
    logic          load_done_q, load_done_d;
    logic          layer_done_q, layer_done_d;

    logic [1:0]    full;
    logic          wr_bank;
    logic          rd_bank;
    logic          accept;
    logic          fill_set;

    assign rd_ready_o = (state_q == LOAD) && !full[wr_bank];
    assign accept     = rd_valid_i && rd_ready_o;
    assign fill_set   = accept && (pkg_cnt_q == PKG_LAST);

    bank_status u_bank_status (
        .clk_i     (clk_i),
        .rstn_i    (rstn_i),
        .set_i     (fill_set),
        .clr_i     (wt_done_i),
        .full_o    (full),
        .wr_bank_o (wr_bank),
        .rd_bank_o (rd_bank)
    );

    always_comb begin
        state_d      = state_q;
        pkg_cnt_d    = pkg_cnt_q;
        mat_cnt_d    = mat_cnt_q;
        mat_num_d    = mat_num_q;
        load_done_d  = 1'b0;
        layer_done_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start_i) begin
                    mat_num_d = mat_num_i;
                    pkg_cnt_d = '0;
                    mat_cnt_d = '0;
                    state_d   = (mat_num_i == '0) ? DRAIN : LOAD;
                end
            end
            LOAD: begin
                if (fill_set) begin
                    pkg_cnt_d = '0;
                    if (mat_cnt_q == mat_num_q - GW'(1)) begin
                        load_done_d = 1'b1;
                        state_d     = DRAIN;
                    end else begin
                        mat_cnt_d = mat_cnt_q + GW'(1);
                    end
                end else if (accept) begin
                    pkg_cnt_d = pkg_cnt_q + PW'(1);
                end
            end
            DRAIN: begin
                // Layer ends only once the compute side has released both banks.
                if (full == 2'b00) begin
                    layer_done_d = 1'b1;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= IDLE;
            pkg_cnt_q    <= '0;
            mat_cnt_q    <= '0;
            mat_num_q    <= '0;
            load_done_q  <= 1'b0;
            layer_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pkg_cnt_q    <= pkg_cnt_d;
            mat_cnt_q    <= mat_cnt_d;
            mat_num_q    <= mat_num_d;
            load_done_q  <= load_done_d;
            layer_done_q <= layer_done_d;
        end
    end

    assign wm_en_o      = accept;
    assign wm_sel_w_o   = wr_bank;
    assign wm_sel_r_o   = rd_bank;
    assign wt_valid_o   = full[rd_bank];
    assign busy_o       = (state_q != IDLE);
    assign load_done_o  = load_done_q;
    assign layer_done_o = layer_done_q;

endmodule

// File: tb/tb_weight_bank_ctrl.sv
// Directed bench for weight_bank_ctrl; outputs are packed as
// {rd_ready, wm_en, sel_w, sel_r, wt_valid, busy, load_done, layer_done}.
module tb_weight_bank_ctrl;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic        start_i;
    logic [15:0] mat_num_i;
    logic        rd_valid_i;
    logic        rd_ready_o;
    logic        wm_en_o;
    logic        wm_sel_w_o;
    logic        wm_sel_r_o;
    logic        wt_valid_o;
    logic        wt_done_i;
    logic        busy_o;
    logic        load_done_o;
    logic        layer_done_o;

    logic [7:0]  outs;
    int          checks = 0;
    int          errors = 0;

    always #5 clk_i = ~clk_i;

    assign outs = {rd_ready_o, wm_en_o, wm_sel_w_o, wm_sel_r_o,
                   wt_valid_o, busy_o, load_done_o, layer_done_o};

    weight_bank_ctrl dut (
        .clk_i        (clk_i),
        .rstn_i       (rstn_i),
        .start_i      (start_i),
        .mat_num_i    (mat_num_i),
        .rd_valid_i   (rd_valid_i),
        .rd_ready_o   (rd_ready_o),
        .wm_en_o      (wm_en_o),
        .wm_sel_w_o   (wm_sel_w_o),
        .wm_sel_r_o   (wm_sel_r_o),
        .wt_valid_o   (wt_valid_o),
        .wt_done_i    (wt_done_i),
        .busy_o       (busy_o),
        .load_done_o  (load_done_o),
        .layer_done_o (layer_done_o)
    );

    task automatic do_reset();
        @(negedge clk_i);
        rstn_i = 1'b0; start_i = 1'b0; mat_num_i = '0; rd_valid_i = 1'b0; wt_done_i = 1'b0;
        @(negedge clk_i);
        @(negedge clk_i);
        rstn_i = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        if (outs !== 8'b0000_0000) begin
            errors++; $display("FAIL reset_state: outs=%b expected %b", outs, 8'b0000_0000);
        end
        checks++;
    endtask

    task automatic test_single();
        logic [7:0] exp;
        do_reset();
        @(negedge clk_i); start_i = 1'b1; mat_num_i = 16'd1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_i); start_i = 1'b0; rd_valid_i = 1'b1; #1;
            if (outs !== 8'b1100_0100) begin
                errors++; $display("FAIL single_beat%0d: outs=%b expected %b", k, outs, 8'b1100_0100);
            end
            checks++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i); rd_valid_i = 1'b0; wt_done_i = (k == 0); #1;
            case (k)
                0:       exp = 8'b0010_1110;
                1:       exp = 8'b0011_0100;
                2:       exp = 8'b0011_0001;
                default: exp = 8'b0011_0000;
            endcase
            if (outs !== exp) begin
                errors++; $display("FAIL single_tail%0d: outs=%b expected %b", k, outs, exp);
            end
            checks++;
        end
        wt_done_i = 1'b0;
    endtask

    task automatic test_backpressure();
        int   beats = 0;
        int   selbad = 0;
        logic exp_sel;
        logic [7:0] exp;
        do_reset();
        @(negedge clk_i); start_i = 1'b1; mat_num_i = 16'd3;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk_i); start_i = 1'b0; rd_valid_i = 1'b1; #1;
            if (wm_en_o === 1'b1) begin
                exp_sel = ((beats / 9) % 2) == 1;
                if (wm_sel_w_o !== exp_sel) selbad++;
                beats++;
            end
        end
        if (beats != 18) begin
            errors++; $display("FAIL bp_beats: got %0d expected 18", beats);
        end
        checks++;
        if (selbad != 0) begin
            errors++; $display("FAIL bp_sel_w_order: %0d wrong beats expected 0", selbad);
        end
        checks++;
        if (outs !== 8'b0000_1100) begin
            errors++; $display("FAIL bp_stalled: outs=%b expected %b", outs, 8'b0000_1100);
        end
        checks++;
        @(negedge clk_i); wt_done_i = 1'b1;
        for (int k = 0; k < 9; k++) begin
            @(negedge clk_i); wt_done_i = 1'b0; #1;
            if (outs !== 8'b1101_1100) begin
                errors++; $display("FAIL bp_third_beat%0d: outs=%b expected %b", k, outs, 8'b1101_1100);
            end
            checks++;
        end
        for (int k = 0; k < 4; k++) begin
            @(negedge clk_i); rd_valid_i = 1'b0; wt_done_i = (k < 2); #1;
            case (k)
                0:       exp = 8'b0011_1110;
                1:       exp = 8'b0010_1100;
                2:       exp = 8'b0011_0100;
                default: exp = 8'b0011_0001;
            endcase
            if (outs !== exp) begin
                errors++; $display("FAIL bp_drain%0d: outs=%b expected %b", k, outs, exp);
            end
            checks++;
        end
        wt_done_i = 1'b0;
    endtask

    task automatic test_random_gaps();
        int   beats = 0;
        int   enbad = 0;
        int   selbad = 0;
        logic ld_seen = 1'b0;
        logic lyd_seen = 1'b0;
        logic exp_sel;
        do_reset();
        @(negedge clk_i); start_i = 1'b1; mat_num_i = 16'd4; wt_done_i = 1'b1;
        for (int c = 0; c < 600; c++) begin
            @(negedge clk_i); start_i = 1'b0; rd_valid_i = 1'($urandom_range(0, 1)); #1;
            if (load_done_o === 1'b1) begin
                ld_seen = 1'b1;
                break;
            end
            // Consumer always done, so the controller should never stall mid-load.
            if (wm_en_o !== rd_valid_i) enbad++;
            if (wm_en_o === 1'b1) begin
                exp_sel = ((beats / 9) % 2) == 1;
                if (wm_sel_w_o !== exp_sel) selbad++;
                beats++;
            end
        end
        rd_valid_i = 1'b0;
        if (!ld_seen) begin
            errors++; $display("FAIL rnd_load_done: not seen within budget, expected pulse");
        end
        checks++;
        if (beats != 36) begin
            errors++; $display("FAIL rnd_beats: got %0d expected 36", beats);
        end
        checks++;
        if (enbad != 0) begin
            errors++; $display("FAIL rnd_handshake: %0d cycles wm_en!=rd_valid expected 0", enbad);
        end
        checks++;
        if (selbad != 0) begin
            errors++; $display("FAIL rnd_sel_w_order: %0d wrong beats expected 0", selbad);
        end
        checks++;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk_i); #1;
            if (layer_done_o === 1'b1) begin
                lyd_seen = 1'b1;
                break;
            end
        end
        if (!lyd_seen) begin
            errors++; $display("FAIL rnd_layer_done: not seen within budget, expected pulse");
        end
        checks++;
        wt_done_i = 1'b0;
    endtask

    task automatic test_simultaneous();
        logic [7:0] exp;
        do_reset();
        @(negedge clk_i); start_i = 1'b1; mat_num_i = 16'd3;
        for (int k = 1; k <= 18; k++) begin
            @(negedge clk_i); start_i = 1'b0; rd_valid_i = 1'b1; wt_done_i = (k == 18); #1;
            exp = (k <= 9) ? 8'b1100_0100 : 8'b1110_1100;
            if (outs !== exp) begin
                errors++; $display("FAIL sim_beat%0d: outs=%b expected %b", k, outs, exp);
            end
            checks++;
        end
        for (int k = 0; k < 5; k++) begin
            @(negedge clk_i); rd_valid_i = 1'b0; wt_done_i = (k == 1 || k == 3); #1;
            exp = (k < 2) ? 8'b1001_1100 : 8'b1000_0100;
            if (outs !== exp) begin
                errors++; $display("FAIL sim_after%0d: outs=%b expected %b", k, outs, exp);
            end
            checks++;
        end
        wt_done_i = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        @(negedge clk_i); start_i = 1'b1; mat_num_i = 16'd2;
        for (int k = 1; k <= 5; k++) begin
            @(negedge clk_i); start_i = 1'b0; rd_valid_i = 1'b1;
        end
        @(negedge clk_i); rstn_i = 1'b0;
        @(negedge clk_i); #1;
        if (outs !== 8'b0000_0000) begin
            errors++; $display("FAIL midreset_state: outs=%b expected %b", outs, 8'b0000_0000);
        end
        checks++;
        rstn_i = 1'b1;
        @(negedge clk_i); start_i = 1'b1; mat_num_i = 16'd1; rd_valid_i = 1'b0;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_i); start_i = 1'b0; rd_valid_i = 1'b1; #1;
            if (outs !== 8'b1100_0100) begin
                errors++; $display("FAIL midreset_reload%0d: outs=%b expected %b", k, outs, 8'b1100_0100);
            end
            checks++;
        end
        @(negedge clk_i); rd_valid_i = 1'b0; #1;
        if (outs !== 8'b0010_1110) begin
            errors++; $display("FAIL midreset_load_done: outs=%b expected %b", outs, 8'b0010_1110);
        end
        checks++;
    endtask

    task automatic test_zero_matrices();
        logic [7:0] exp;
        do_reset();
        @(negedge clk_i); start_i = 1'b1; mat_num_i = 16'd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk_i); start_i = 1'b0; rd_valid_i = 1'b1; #1;
            case (k)
                0:       exp = 8'b0000_0100;
                1:       exp = 8'b0000_0001;
                default: exp = 8'b0000_0000;
            endcase
            if (outs !== exp) begin
                errors++; $display("FAIL zero_mat%0d: outs=%b expected %b", k, outs, exp);
            end
            checks++;
        end
        rd_valid_i = 1'b0;
    endtask

    task automatic test_start_ignored();
        do_reset();
        @(negedge clk_i); start_i = 1'b1; mat_num_i = 16'd1;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk_i);
            start_i    = (k == 3 || k == 4);
            mat_num_i  = (k == 3 || k == 4) ? 16'd5 : 16'd1;
            rd_valid_i = 1'b1; #1;
            if (outs !== 8'b1100_0100) begin
                errors++; $display("FAIL start_ign_beat%0d: outs=%b expected %b", k, outs, 8'b1100_0100);
            end
            checks++;
        end
        @(negedge clk_i); start_i = 1'b0; rd_valid_i = 1'b0; #1;
        if (outs !== 8'b0010_1110) begin
            errors++; $display("FAIL start_ign_load_done: outs=%b expected %b", outs, 8'b0010_1110);
        end
        checks++;
    endtask

    initial begin
        rstn_i = 1'b0; start_i = 1'b0; mat_num_i = '0; rd_valid_i = 1'b0; wt_done_i = 1'b0;
        test_reset();
        test_single();
        test_backpressure();
        test_random_gaps();
        test_simultaneous();
        test_reset_mid();
        test_zero_matrices();
        test_start_ignored();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
